// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//
// Selects one of NUM_REQ requesters for the SERDES lane/stream mux and holds
// (locks) the grant until the owner signals end of transfer with done. The
// N:1 data mux steers on gnt_idx.
//
// Selection is fixed priority (lowest index wins) or round-robin from a
// rotating pointer, chosen by mode_rr at the moment of arbitration. A
// watchdog forces release of an owner that holds the grant for TIMEOUT
// cycles without done; TIMEOUT = 0 disables it.
//
// Handshake: a grant is offered with gnt/gnt_idx/gnt_valid and stays frozen
// until done is seen high on a rising edge while gnt_valid is high. done
// while idle is ignored. All outputs are registered, so there is no
// combinational path from req/done to any output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        request vector, bit i = requester i wants the output
//   mode_rr    0 = fixed priority, 1 = round-robin
//   done       single-cycle end-of-transfer from the current owner
//   gnt        registered one-hot grant, zero when idle
//   gnt_idx    binary owner index, meaningful only while gnt_valid
//   gnt_valid  high while a grant is held
//   timeout    single-cycle pulse on a watchdog-forced release
//   state_dbg  FSM state, 0 = IDLE, 1 = GRANTED

module rr_lock_arbiter #(
   parameter int NUM_REQ = 8,
   parameter int TIMEOUT = 1024,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               mode_rr,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout,
   output logic               state_dbg
);

   // A one-bit counter is kept when the watchdog is disabled so the
   // declarations stay legal; it is never advanced in that case.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   wd_q, wd_d;

   logic [IDX_W-1:0]   ptr_after;  // owner index + 1, wrapping to 0
   logic [IDX_W-1:0]   scan_base;  // round-robin start for this cycle
   logic               wd_expire;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;

   assign ptr_after = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);

   // On a done cycle the pointer update and the back-to-back re-arbitration
   // happen on the same edge, so the scan must already start from the
   // post-done pointer.
   assign scan_base = (state_q == GRANTED) ? ptr_after : ptr_q;

   assign wd_expire = (TIMEOUT > 0) && (wd_q == WD_LAST);

   // Winner: first requester found scanning from index 0 (fixed) or from
   // scan_base upward with wrap (round-robin).
   always_comb begin : arb_comb
      logic [IDX_W:0] pos;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mode_rr) begin
            pos = {1'b0, scan_base} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
               pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
         end else begin
            pos = (IDX_W + 1)'(i);
         end
         if (!win_found && req[pos[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = pos[IDX_W-1:0];
         end
      end
   end

   always_comb begin : fsm_comb
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      wd_d      = wd_q;

      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (win_found) begin
               state_d = GRANTED;
               gnt_d   = NUM_REQ'(1) << win_idx;
               idx_d   = win_idx;
               valid_d = 1'b1;
            end
         end

         GRANTED: begin
            if (done) begin
               // done beats a coincident watchdog expiry.
               ptr_d = ptr_after;
               wd_d  = '0;
               if (win_found) begin
                  gnt_d = NUM_REQ'(1) << win_idx;
                  idx_d = win_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
               end
            end else if (wd_expire) begin
               // Forced release: no re-arbitration on this edge, so the
               // timeout cycle itself is idle. The pointer moves past the
               // hung owner.
               state_d   = IDLE;
               gnt_d     = '0;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
               ptr_d     = ptr_after;
               wd_d      = '0;
            end else if (TIMEOUT > 0) begin
               wd_d = wd_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         wd_q      <= wd_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign timeout   = timeout_q;
   assign state_dbg = (state_q == GRANTED);

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed vectors with literal expectations plus
// a behavioural model (owner / pointer / hold-time) compared every cycle.

module tb_rr_lock_arbiter;

   localparam int N  = 8;
   localparam int TO = 16;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         mode_rr;
   logic         done;
   logic [N-1:0] gnt;
   logic [2:0]   gnt_idx;
   logic         gnt_valid;
   logic         timeout;
   logic         state_dbg;

   int n_checks;
   int n_pass;
   bit chk_en;

   // Model state: owner index (-1 = none), round-robin pointer, cycles the
   // current owner has held the grant, and the timeout pulse.
   int m_owner;
   int m_ptr;
   int m_held;
   bit m_to;

   rr_lock_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mode_rr   (mode_rr),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Winner from the selection rules: lowest set bit, or first set bit
   // walking p, p+1, ... modulo N.
   function automatic int pick(input logic [N-1:0] r, input bit rr, input int p);
      for (int k = 0; k < N; k++) begin
         int j;
         j = rr ? (p + k) % N : k;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   // ---------------- model ----------------
   initial begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            m_owner = pick(req, mode_rr, m_ptr);
            m_held  = 0;
         end else if (done) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick(req, mode_rr, m_ptr);
            m_held  = 0;
         end else if (m_held == TO - 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_held++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic [N-1:0] exp_gnt;
         exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
         check("gnt", 32'(gnt), 32'(exp_gnt));
         check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         check("timeout", 32'(timeout), 32'(m_to));
         check("state_dbg", 32'(state_dbg), 32'(m_owner >= 0));
         if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int held;
      n_checks = 0;
      n_pass   = 0;
      chk_en   = 1'b0;
      rst      = 1'b1;
      req      = '0;
      mode_rr  = 1'b0;
      done     = 1'b0;

      // Reset and idle.
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_gnt_idx", 32'(gnt_idx), 32'h0);
      check("rst_valid", 32'(gnt_valid), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (10) tick();
      check("idle_valid", 32'(gnt_valid), 32'h0);

      // Fixed priority and lock.
      mode_rr = 1'b0;
      req     = 8'b1010_0100;
      tick();
      check("fix_gnt", 32'(gnt), 32'h04);
      check("fix_idx", 32'(gnt_idx), 32'd2);
      req = 8'b1000_0001;
      repeat (3) tick();
      check("fix_lock", 32'(gnt), 32'h04);
      mode_rr = 1'b1;            // no effect while granted
      tick();
      check("fix_mode_lock", 32'(gnt_idx), 32'd2);
      mode_rr = 1'b0;
      done    = 1'b1;
      tick();
      done = 1'b0;
      check("fix_b2b_idx", 32'(gnt_idx), 32'd0);
      check("fix_b2b_gnt", 32'(gnt), 32'h01);
      req  = '0;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("fix_release", 32'(gnt_valid), 32'h0);

      // Round-robin fairness from a fresh pointer.
      do_reset();
      mode_rr = 1'b1;
      req     = 8'hFF;
      tick();
      check("rr_first", 32'(gnt_idx), 32'd0);
      for (int k = 1; k <= N; k++) begin
         tick();
         tick();
         done = 1'b1;
         tick();
         done = 1'b0;
         check("rr_seq", 32'(gnt_idx), 32'(k % N));
         check("rr_no_bubble", 32'(gnt_valid), 32'h1);
      end

      // Wrap: owner 7, then requesters {7,1} with pointer wrapping to 0.
      req  = 8'h80;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("wrap_owner7", 32'(gnt_idx), 32'd7);
      req = 8'b1000_0010;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("wrap_idx", 32'(gnt_idx), 32'd1);
      req  = '0;
      done = 1'b1;
      tick();
      done = 1'b0;

      // Watchdog with a single stalled requester.
      req = 8'h20;
      tick();
      check("wd_owner", 32'(gnt_idx), 32'd5);
      held = 1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (gnt_valid) held++;
         else break;
      end
      check("wd_hold_cycles", 32'(held), 32'd16);
      check("wd_pulse", 32'(timeout), 32'h1);
      check("wd_gnt_zero", 32'(gnt), 32'h0);
      tick();
      check("wd_regrant", 32'(gnt_idx), 32'd5);
      check("wd_regrant_valid", 32'(gnt_valid), 32'h1);
      check("wd_pulse_one", 32'(timeout), 32'h0);
      req  = '0;
      done = 1'b1;
      tick();
      done = 1'b0;

      // Reset in the middle of a grant.
      req = 8'h08;
      tick();
      check("mid_owner", 32'(gnt_idx), 32'd3);
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_valid", 32'(gnt_valid), 32'h0);
      rst = 1'b0;
      req = 8'hFF;
      tick();
      check("mid_rr_ptr0", 32'(gnt_idx), 32'd0);

      // done on the same cycle the watchdog would expire.
      repeat (TO - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("coll_timeout", 32'(timeout), 32'h0);
      check("coll_valid", 32'(gnt_valid), 32'h1);
      check("coll_idx", 32'(gnt_idx), 32'd1);
      req  = '0;
      done = 1'b1;
      tick();
      done = 1'b0;
      repeat (3) tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
